// File: rtl/clz_clo_normalizer_pkg.sv
// rtl/clz_clo_normalizer_pkg.sv - shared encodings and defaults for the clz/clo normaliser
package clz_clo_normalizer_pkg;

  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CLO = 1'b1;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int ADDR_WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/clz_clo_normalizer_stage.sv
// rtl/clz_clo_normalizer_stage.sv - one binary-search step of the leading-zero search
module clz_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] work,
  input  logic [DATA_WIDTH-1:0] orig,
  input  logic [ADDR_WIDTH:0]   cnt,
  input  logic [ADDR_WIDTH-1:0] stage,
  output logic [DATA_WIDTH-1:0] work_nxt,
  output logic [DATA_WIDTH-1:0] orig_nxt,
  output logic [ADDR_WIDTH:0]   cnt_nxt
);

  logic [ADDR_WIDTH:0]   step;
  logic [DATA_WIDTH-1:0] top_mask;

  always_comb begin
    step     = (ADDR_WIDTH+1)'(1) << stage;
    top_mask = ~({DATA_WIDTH{1'b1}} >> step);
    work_nxt = work;
    orig_nxt = orig;
    cnt_nxt  = cnt;
    if ((work & top_mask) == '0) begin
      work_nxt = work << step;
      orig_nxt = orig << step;
      cnt_nxt  = cnt + step;
    end
    // Final stage: an operand with no significant bit at all still needs one more count.
    if (stage == '0 && !work_nxt[DATA_WIDTH-1]) begin
      cnt_nxt  = cnt_nxt + 1'b1;
      orig_nxt = '0;
    end
  end

endmodule

// File: rtl/clz_clo_normalizer.sv
// rtl/clz_clo_normalizer.sv - multi-cycle count-leading-zeros/ones with normalised result
module clz_clo_normalizer
  import clz_clo_normalizer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_clo,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count_out,
  output logic [DATA_WIDTH-1:0] norm_out
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d, orig_q, orig_d, norm_q, norm_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, count_q, count_d;
  logic [ADDR_WIDTH-1:0] stage_q, stage_d;
  logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [DATA_WIDTH-1:0] work_nxt, orig_nxt;
  logic [ADDR_WIDTH:0]   cnt_nxt;

  clz_stage #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_stage (
    .work     (work_q),
    .orig     (orig_q),
    .cnt      (cnt_q),
    .stage    (stage_q),
    .work_nxt (work_nxt),
    .orig_nxt (orig_nxt),
    .cnt_nxt  (cnt_nxt)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    orig_d      = orig_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    count_d     = count_q;
    norm_d      = norm_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = ST_IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            // Leading ones become leading zeros so a single search serves both ops.
            work_d     = (op_clo == OP_CLO) ? ~data_in : data_in;
            orig_d     = data_in;
            cnt_d      = '0;
            stage_d    = ADDR_WIDTH'(ADDR_WIDTH-1);
            state_d    = ST_NORM;
            in_ready_d = 1'b0;
          end
        end
        ST_NORM: begin
          work_d  = work_nxt;
          orig_d  = orig_nxt;
          cnt_d   = cnt_nxt;
          stage_d = stage_q - 1'b1;
          if (stage_q == '0) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            count_d     = cnt_nxt;
            norm_d      = orig_nxt;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      orig_q      <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      count_q     <= '0;
      norm_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      orig_q      <= orig_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      count_q     <= count_d;
      norm_q      <= norm_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count_out = count_q;
  assign norm_out  = norm_q;

endmodule

// File: tb/tb_clz_clo_normalizer.sv
// tb/tb_clz_clo_normalizer.sv - self-checking bench for clz_clo_normalizer
module tb_clz_clo_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_clo = 1'b0;
  logic [31:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  count_out;
  logic [31:0] norm_out;

  int errors = 0;
  int checks = 0;

  clz_clo_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_clo    (op_clo),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count_out (count_out),
    .norm_out  (norm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input logic [31:0] d, input logic clo);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] != clo) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_norm(input logic [31:0] d, input logic clo);
    int n = ref_count(d, clo);
    return (n >= 32) ? 32'h0 : (d << n);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic run_op(input string tag, input logic [31:0] d, input logic clo, input int stall);
    int lat;
    logic [5:0]  exp_cnt;
    logic [31:0] exp_norm;
    exp_cnt  = 6'(ref_count(d, clo));
    exp_norm = ref_norm(d, clo);
    chk({tag, ".in_ready_before"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    data_in   = d;
    op_clo    = clo;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_clo   = ~clo;
    data_in  = ~d;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd5);
    chk({tag, ".count"}, 64'(count_out), 64'(exp_cnt));
    chk({tag, ".norm"}, 64'(norm_out), 64'(exp_norm));
    if (stall > 0) begin
      in_valid = 1'b1;
      data_in  = 32'h0000_0001;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".stall_count"}, 64'(count_out), 64'(exp_cnt));
        chk({tag, ".stall_norm"}, 64'(norm_out), 64'(exp_norm));
        chk({tag, ".stall_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int quiet;
    logic [31:0] rd;
    logic        rc;

    #12;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.count", 64'(count_out), 64'd0);
    chk("reset.norm", 64'(norm_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("clz_10000", 32'h0001_0000, 1'b0, 0);
    run_op("clz_zero", 32'h0000_0000, 1'b0, 0);
    run_op("clz_msb", 32'h8000_0000, 1'b0, 0);
    run_op("clz_one", 32'h0000_0001, 1'b0, 0);
    run_op("clo_fff0", 32'hFFF0_1234, 1'b1, 0);
    run_op("clo_all", 32'hFFFF_FFFF, 1'b1, 0);
    run_op("stall_ffff", 32'h0000_FFFF, 1'b0, 4);

    // Reset after E2 of an operation
    in_valid = 1'b1; data_in = 32'h0000_0100; op_clo = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.count", 64'(count_out), 64'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 32'h0000_0100, 1'b0, 0);

    // Flush at E3
    in_valid = 1'b1; data_in = 32'h0000_0010; op_clo = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_e3.in_ready", 64'(in_ready), 64'd1);
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 0;
    end
    chk("flush_e3.no_result", 64'(quiet), 64'd1);

    // Flush coincident with acceptance
    in_valid = 1'b1; flush = 1'b1; data_in = 32'h0000_0003; op_clo = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc.in_ready", 64'(in_ready), 64'd1);
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 0;
    end
    chk("flush_acc.no_result", 64'(quiet), 64'd1);

    for (int n = 0; n < 24; n++) begin
      rc = 1'($urandom_range(0, 1));
      rd = $urandom >> $urandom_range(0, 31);
      if (rc) rd = ~rd;
      run_op($sformatf("rand%0d", n), rd, rc, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
